slave_i2c: RTL and testbench
============================

Name: slave_i2c

Overview:
- I2C target stage directly downstream of the team's I2C master; consumes its SCL/SDA stream and answers with ACK/NACK and read data.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Supports 16-bit transfers as two bytes, MSB first: write (RNW=0) delivers WR_DATA plus strobe; read (RNW=1) returns RD_DATA.
- Drives SDA only through SDA_OUT/SDA_OE; the bench resolves SDA = master_oe ? master_out : slave_oe ? slave_out : 1.

Parameters:
- SYNC_STAGES, 2: flop stages on SCL and SDA_IN before edge detection; minimum 1.

Ports:
- CLK  in  1  system clock, at least 4x SCL frequency
- RESET  in  1  synchronous, active-high reset
- I2C_ADDR  in  7  own target address; sampled only during the address phase
- RD_DATA  in  16  word returned on reads; latched at address ACK
- SCL  in  1  bus clock from the master
- SDA_IN  in  1  resolved bus SDA
- SDA_OUT  out  1  value driven when SDA_OE=1
- SDA_OE  out  1  1 = target drives SDA
- WR_DATA  out  16  last complete write word, first byte = [15:8]
- WR_STB  out  1  one-CLK pulse when WR_DATA updates
- RD_STB  out  1  one-CLK pulse when RD_DATA is latched
- BUSY  out  1  high from an address match until STOP, or until return to IDLE

Behaviour:
- Reset (RESET=1 at a CLK edge): state IDLE, SDA_OE=0, SDA_OUT=1, WR_DATA=0, WR_STB=0, RD_STB=0, BUSY=0; bit counter and byte counter cleared. Reset mid-transfer aborts immediately; bus is released on the next edge.
- Bus events, evaluated on synchronized signals:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - rise/fall = SCL edges.
  - Latency from pin to action is SYNC_STAGES+1 CLK.
- Sampling and driving: input data is sampled on SCL rise; SDA_OUT/SDA_OE change only on SCL fall, except release on STOP, START or reset.
- States:
  - IDLE: ignore everything except START -> ADDR.
  - ADDR: shift 8 bits on rises (7 address bits, then RNW). After the 8th rise:
    - match = (addr == I2C_ADDR) -> ADDR_ACK.
    - no match -> WAIT_STOP, SDA never driven.
  - ADDR_ACK: on the next fall drive SDA_OE=1, SDA_OUT=0, set BUSY. On the following fall:
    - RNW=0: release -> WR_BYTE.
    - RNW=1: latch RD_DATA, pulse RD_STB, drive bit 15 -> RD_BYTE.
  - WR_BYTE: shift 8 bits on rises. After the 8th rise -> WR_ACK.
    - Byte 0 goes to a shadow [15:8].
    - Byte 1 updates WR_DATA={shadow,byte} and pulses WR_STB, both on the 8th rise.
  - WR_ACK: ACK bytes 0 and 1 (drive low for one SCL period, fall to fall). Byte index >=2: leave SDA released (NACK) -> WAIT_STOP, WR_DATA unchanged.
  - RD_BYTE: present the next bit on each fall. After the 8th bit's fall, release SDA -> RD_ACK.
  - RD_ACK: sample the master bit on the rise.
    - 0 after byte 0: next fall drives bit 7 -> RD_BYTE.
    - 1 (NACK), or anything after byte 1 -> WAIT_STOP, released.
  - WAIT_STOP: SDA released; STOP -> IDLE, BUSY=0.
- Global transitions:
  - STOP in any state -> IDLE, SDA released, BUSY=0.
  - START in any state (repeated start) -> ADDR, counters cleared, SDA released the same cycle.
- STOP after only one write byte: no WR_STB, WR_DATA unchanged.
- START and STOP both flagged in one cycle (glitch): START wins.
- Counters: 3-bit bit counter wraps 7->0 at a byte boundary; 2-bit byte counter saturates at 2.

Optional Feature:
- Macro: SLAVE_I2C_GENERAL_CALL_EN.
- Defined: address 7'h00 with RNW=0 is also accepted (ACKed, write path, WR_STB as normal); 7'h00 with RNW=1 is NACKed.
- Undefined: 7'h00 is treated as any non-matching address (no ACK, WAIT_STOP).

Test Plan:
- Write: I2C_ADDR=7'h2A; master writes addr 7'h2A, RNW=0, data 16'hA55A -> ACK at the 9th SCL of each of the 3 bytes; WR_DATA=16'hA55A; WR_STB high exactly 1 CLK; BUSY=0 after STOP.
- Read: RD_DATA=16'hC3E1; master reads 7'h2A, ACKs byte 0, NACKs byte 1 -> master's Rd_data_master=16'hC3E1; RD_STB pulses once; SDA_OE=0 during both master ACK slots.
- Address mismatch: master addresses 7'h15 -> SDA_OE stays 0 throughout; no strobes; master sees NACK and returns to idle.
- Early abort: write to 7'h2A, STOP after byte 0xFF -> WR_DATA keeps its prior value 16'hA55A; no WR_STB; state IDLE.
- Reset mid-read: RESET=1 for 1 CLK while the slave drives bit 12 -> next CLK SDA_OE=0, SDA_OUT=1, BUSY=0; the next START with 7'h2A works normally.
- General call: write to 7'h00, data 16'h1234 -> with SLAVE_I2C_GENERAL_CALL_EN, WR_DATA=16'h1234; without it, no ACK and WR_DATA unchanged.

Source files
------------

// File: rtl/slave_i2c.sv
// slave_i2c: I2C target, oversamples SCL/SDA and answers 16-bit reads/writes.
// Ports: CLK, RESET (sync, high), I2C_ADDR, RD_DATA, SCL, SDA_IN in;
//        SDA_OUT, SDA_OE, WR_DATA, WR_STB, RD_STB, BUSY out.
// Optional: define SLAVE_I2C_GENERAL_CALL_EN to accept write to address 7'h00.
`timescale 1ns/1ps
module slave_i2c #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  I2C_ADDR,
  input  logic [15:0] RD_DATA,
  input  logic        SCL,
  input  logic        SDA_IN,
  output logic        SDA_OUT,
  output logic        SDA_OE,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_prev_q, sda_prev_q;

  logic [2:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] tx_q, tx_d;
  logic        sda_oe_q, sda_oe_d;
  logic        sda_out_q, sda_out_d;
  logic        busy_q, busy_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic bus_start, bus_stop;
  logic [7:0] rx_byte;
  logic last_bit;
  logic addr_hit;

  always_comb begin
    scl_sync_d[0] = SCL;
    sda_sync_d[0] = SDA_IN;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      scl_sync_d[i] = scl_sync_q[i-1];
      sda_sync_d[i] = sda_sync_q[i-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign rx_byte  = {rx_q[6:0], sda_s};
  assign last_bit = (bit_cnt_q == 3'd7);

  // Address 0 never matches I2C_ADDR; it is the general-call address.
  always_comb begin
    addr_hit = (rx_byte[7:1] == I2C_ADDR) &&
               (rx_byte[7:1] != 7'h00);
`ifdef SLAVE_I2C_GENERAL_CALL_EN
    if (rx_byte == 8'h00) addr_hit = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_d       = rx_q;
    rnw_d      = rnw_q;
    shadow_d   = shadow_q;
    wr_data_d  = wr_data_q;
    tx_d       = tx_q;
    sda_oe_d   = sda_oe_q;
    sda_out_d  = sda_out_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;

    if (bus_start) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      sda_oe_d   = 1'b0;
      sda_out_d  = 1'b1;
    end else if (bus_stop) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      sda_oe_d   = 1'b0;
      sda_out_d  = 1'b1;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rnw_d   = sda_s;
              state_d = addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
            end
          end
        end
        // First fall drives the ACK; second fall ends it.
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d  = 1'b1;
              sda_out_d = 1'b0;
              busy_d    = 1'b1;
            end else if (!rnw_q) begin
              sda_oe_d  = 1'b0;
              sda_out_d = 1'b1;
              state_d   = S_WR_BYTE;
            end else begin
              tx_d      = RD_DATA;
              sda_out_d = RD_DATA[15];
              rd_stb_d  = 1'b1;
              state_d   = S_RD_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              state_d = S_WR_ACK;
              if (byte_cnt_q == 2'd0) begin
                shadow_d = rx_byte;
              end else if (byte_cnt_q == 2'd1) begin
                wr_data_d = {shadow_q, rx_byte};
                wr_stb_d  = 1'b1;
              end
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (sda_oe_q) begin
              sda_oe_d   = 1'b0;
              sda_out_d  = 1'b1;
              byte_cnt_d = (byte_cnt_q == 2'd2) ? 2'd2
                         : byte_cnt_q + 2'd1;
              state_d    = S_WR_BYTE;
            end else if (byte_cnt_q != 2'd2) begin
              sda_oe_d  = 1'b1;
              sda_out_d = 1'b0;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        // tx_q[15] always holds the bit currently on the bus.
        S_RD_BYTE: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[14:0], 1'b0};
            if (last_bit) begin
              sda_oe_d  = 1'b0;
              sda_out_d = 1'b1;
              state_d   = S_RD_ACK;
            end else begin
              sda_out_d = tx_q[14];
            end
          end
        end
        // Entered on a fall, so a fall here always follows an ACKed rise.
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s && byte_cnt_q == 2'd0) begin
              byte_cnt_d = 2'd1;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end else if (scl_fall) begin
            sda_oe_d  = 1'b1;
            sda_out_d = tx_q[15];
            state_d   = S_RD_BYTE;
          end
        end
        S_IDLE, S_WAIT_STOP: begin
          state_d = state_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      rx_q       <= 8'h00;
      rnw_q      <= 1'b0;
      shadow_q   <= 8'h00;
      wr_data_q  <= 16'h0000;
      tx_q       <= 16'h0000;
      sda_oe_q   <= 1'b0;
      sda_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_q       <= rx_d;
      rnw_q      <= rnw_d;
      shadow_q   <= shadow_d;
      wr_data_q  <= wr_data_d;
      tx_q       <= tx_d;
      sda_oe_q   <= sda_oe_d;
      sda_out_q  <= sda_out_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
    end
  end

  assign SDA_OUT = sda_out_q;
  assign SDA_OE  = sda_oe_q;
  assign WR_DATA = wr_data_q;
  assign WR_STB  = wr_stb_q;
  assign RD_STB  = rd_stb_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_slave_i2c.sv
// tb_slave_i2c: directed bench for slave_i2c with a bit-banged master.
// Ports: none; drives the DUT from tasks and checks via chk().
`timescale 1ns/1ps
module tb_slave_i2c;

  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  i2c_addr = 7'h2A;
  logic [15:0] rd_data = 16'h0000;
  logic        scl = 1'b1;
  logic        m_oe = 1'b0;
  logic        m_out = 1'b1;
  logic        sda;
  logic        sda_out, sda_oe, wr_stb, rd_stb, busy;
  logic [15:0] wr_data;

  int vectors = 0;
  int errors = 0;
  int wr_stb_cyc = 0;
  int rd_stb_cyc = 0;
  int oe_cyc = 0;

  always #5 clk = ~clk;

  assign sda = m_oe ? m_out : (sda_oe ? sda_out : 1'b1);

  slave_i2c #(.SYNC_STAGES(2)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .I2C_ADDR(i2c_addr),
    .RD_DATA (rd_data),
    .SCL     (scl),
    .SDA_IN  (sda),
    .SDA_OUT (sda_out),
    .SDA_OE  (sda_oe),
    .WR_DATA (wr_data),
    .WR_STB  (wr_stb),
    .RD_STB  (rd_stb),
    .BUSY    (busy)
  );

  always @(negedge clk) begin
    if (wr_stb) wr_stb_cyc <= wr_stb_cyc + 1;
    if (rd_stb) rd_stb_cyc <= rd_stb_cyc + 1;
    if (sda_oe) oe_cyc <= oe_cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic mbit(input logic drv, input logic val,
                      output logic smp, output logic soe);
    m_oe = drv;
    m_out = val;
    q();
    scl = 1'b1;
    q();
    smp = sda;
    soe = sda_oe;
    q();
    scl = 1'b0;
    q();
  endtask

  task automatic m_start();
    m_oe = 1'b1;
    m_out = 1'b1;
    scl = 1'b1;
    q();
    m_out = 1'b0;
    q();
    scl = 1'b0;
    q();
  endtask

  task automatic m_stop();
    m_oe = 1'b1;
    m_out = 1'b0;
    q();
    scl = 1'b1;
    q();
    m_out = 1'b1;
    q();
    m_oe = 1'b0;
    q();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) mbit(1'b1, b[i], s, o);
    mbit(1'b0, 1'b1, s, o);
    ack = ~s;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b,
                       output logic oe_ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      mbit(1'b0, 1'b1, s, o);
      b[i] = s;
    end
    mbit(1'b1, nack, s, oe_ack);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not end, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a0, a1, a2, a3, o0, o1, s, o;
    logic [7:0] b0, b1;
    logic [2:0] hi;
    int ws, rs, os;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_out", sda_out, 1'b1);
    chk("rst_wdata", wr_data, 16'h0000);
    chk("rst_wstb", wr_stb, 1'b0);
    chk("rst_rstb", rd_stb, 1'b0);
    chk("rst_busy", busy, 1'b0);
    q();

    // write 0xA55A, then an extra byte that must be NACKed
    ws = wr_stb_cyc;
    m_start();
    wbyte({7'h2A, 1'b0}, a0);
    wbyte(8'hA5, a1);
    wbyte(8'h5A, a2);
    chk("wr_busy", busy, 1'b1);
    wbyte(8'h77, a3);
    m_stop();
    q();
    chk("wr_acks", {a0, a1, a2}, 3'b111);
    chk("wr_extra_nack", a3, 1'b0);
    chk("wr_data", wr_data, 16'hA55A);
    chk("wr_stb_cnt", wr_stb_cyc - ws, 1);
    chk("wr_busy_end", busy, 1'b0);

    // read 0xC3E1, ACK byte 0, NACK byte 1
    rd_data = 16'hC3E1;
    rs = rd_stb_cyc;
    m_start();
    wbyte({7'h2A, 1'b1}, a0);
    rbyte(1'b0, b0, o0);
    rbyte(1'b1, b1, o1);
    m_stop();
    q();
    chk("rd_ack", a0, 1'b1);
    chk("rd_data", {b0, b1}, 16'hC3E1);
    chk("rd_oe_ack0", o0, 1'b0);
    chk("rd_oe_ack1", o1, 1'b0);
    chk("rd_stb_cnt", rd_stb_cyc - rs, 1);
    chk("rd_busy_end", busy, 1'b0);

    // address mismatch
    ws = wr_stb_cyc;
    rs = rd_stb_cyc;
    os = oe_cyc;
    m_start();
    wbyte({7'h15, 1'b0}, a0);
    m_stop();
    q();
    chk("mm_nack", a0, 1'b0);
    chk("mm_oe_cyc", oe_cyc - os, 0);
    chk("mm_wstb", wr_stb_cyc - ws, 0);
    chk("mm_rstb", rd_stb_cyc - rs, 0);
    chk("mm_busy", busy, 1'b0);

    // early abort after one data byte
    ws = wr_stb_cyc;
    m_start();
    wbyte({7'h2A, 1'b0}, a0);
    wbyte(8'hFF, a1);
    m_stop();
    q();
    chk("ab_acks", {a0, a1}, 2'b11);
    chk("ab_wdata", wr_data, 16'hA55A);
    chk("ab_wstb", wr_stb_cyc - ws, 0);
    chk("ab_busy", busy, 1'b0);

    // reset while the target drives bit 12 (0) of 0xC3E1
    m_start();
    wbyte({7'h2A, 1'b1}, a0);
    for (int i = 2; i >= 0; i--) begin
      mbit(1'b0, 1'b1, s, o);
      hi[i] = s;
    end
    chk("rr_bits", hi, 3'b110);
    chk("rr_oe_pre", sda_oe, 1'b1);
    chk("rr_out_pre", sda_out, 1'b0);
    chk("rr_busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_oe", sda_oe, 1'b0);
    chk("rr_out", sda_out, 1'b1);
    chk("rr_busy", busy, 1'b0);
    m_stop();
    q();
    m_start();
    wbyte({7'h2A, 1'b0}, a0);
    wbyte(8'h0F, a1);
    wbyte(8'h0F, a2);
    m_stop();
    q();
    chk("rr_acks", {a0, a1, a2}, 3'b111);
    chk("rr_wdata", wr_data, 16'h0F0F);

    // general call write of 0x1234
    ws = wr_stb_cyc;
    m_start();
    wbyte(8'h00, a0);
    if (a0) begin
      wbyte(8'h12, a1);
      wbyte(8'h34, a2);
    end
    m_stop();
    q();
`ifdef SLAVE_I2C_GENERAL_CALL_EN
    chk("gc_ack", a0, 1'b1);
    chk("gc_wdata", wr_data, 16'h1234);
    chk("gc_wstb", wr_stb_cyc - ws, 1);
`else
    chk("gc_nack", a0, 1'b0);
    chk("gc_wdata", wr_data, 16'h0F0F);
    chk("gc_wstb", wr_stb_cyc - ws, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
